// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner.
//   GLYPH      : 16-entry active-high glyph table, bit order {g,f,e,d,c,b,a}
//   SEG_OFF    : active-low cathode pattern with every segment dark
//   disp_cfg_t : one captured display configuration. It is sized for the
//                largest supported digit count and brightness width; callers
//                use the low NUM_DIGITS / DUTY_BITS slices.
package seg_pkg;

  localparam int MAX_DIGITS    = 16;
  localparam int MAX_DUTY_BITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry 0 is in the least significant position.
  localparam logic [15:0][6:0] GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  typedef struct packed {
    logic [4*MAX_DIGITS-1:0]  vals;
    logic [MAX_DIGITS-1:0]    dp;
    logic [MAX_DIGITS-1:0]    en;
    logic                     blank_lz;
    logic [MAX_DUTY_BITS-1:0] brightness;
  } disp_cfg_t;

endpackage

// File: rtl/seven_segment_scanner_hex_to_seg.sv
// Combinational hex nibble to active-high segment glyph.
//   nibble : 4-bit hex value
//   seg    : segments {g,f,e,d,c,b,a}, 1 = segment on
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = GLYPH[nibble];

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment display driver with per-digit decimal points and
// enables, leading-zero blanking, PWM brightness and frame-synchronous updates.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   val_in         : NUM_DIGITS hex nibbles, digit i at [4i+3:4i]
//   dp_in          : decimal point request per digit (1 = lit)
//   digit_en_in    : per-digit enable (0 = dark)
//   blank_lz_in    : blank leading zero digits
//   brightness_in  : PWM duty, 0 = off, all-ones = full on
//   load_in        : capture strobe for all of the above
//   frame_out      : one-cycle pulse after each frame boundary
//   cat_out/dp_out : active-low segment and decimal point cathodes
//   an_out         : active-low anodes, at most one low
module seven_segment_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int COUNT_TO   = 100_000,
  parameter int DUTY_BITS  = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  input  logic                    blank_lz_in,
  input  logic [DUTY_BITS-1:0]    brightness_in,
  input  logic                    load_in,
  output logic                    frame_out,
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out
);

  localparam int STEP = COUNT_TO >> DUTY_BITS;
  localparam int SW   = (COUNT_TO > 1) ? $clog2(COUNT_TO) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int PW   = DUTY_BITS + 32;

  logic [SW-1:0] slot;
  logic [IW-1:0] idx;
  logic          slot_end, idx_end, boundary;

  assign slot_end = (slot == SW'(COUNT_TO - 1));
  assign idx_end  = (idx == IW'(NUM_DIGITS - 1));
  assign boundary = slot_end && idx_end;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      slot <= '0;
      idx  <= '0;
    end else if (slot_end) begin
      slot <= '0;
      idx  <= idx_end ? '0 : idx + IW'(1);
    end else begin
      slot <= slot + SW'(1);
    end
  end

  // Shadow registers: pending collects loads, active drives the display and
  // only changes at a frame boundary so a frame is never torn.
  disp_cfg_t cfg_in, pending, active;
  logic      pend_flag;

  always_comb begin
    cfg_in = '0;
    cfg_in.vals[4*NUM_DIGITS-1:0]     = val_in;
    cfg_in.dp[NUM_DIGITS-1:0]         = dp_in;
    cfg_in.en[NUM_DIGITS-1:0]         = digit_en_in;
    cfg_in.blank_lz                   = blank_lz_in;
    cfg_in.brightness[DUTY_BITS-1:0]  = brightness_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pending   <= '0;
      active    <= '0;
      pend_flag <= 1'b0;
    end else if (load_in && boundary) begin
      // A load landing on the boundary takes effect for the next frame.
      active    <= cfg_in;
      pend_flag <= 1'b0;
    end else begin
      if (load_in) begin
        pending   <= cfg_in;
        pend_flag <= 1'b1;
      end else if (boundary && pend_flag) begin
        active    <= pending;
        pend_flag <= 1'b0;
      end
    end
  end

  // Fields above the configured digit count / duty width are never displayed.
  logic cfg_unused;
  assign cfg_unused = ^active;

  // Leading-zero run from the top digit down; digit 0 always shows.
  logic [NUM_DIGITS-1:0] blanked;
  logic                  lz_run;

  always_comb begin
    lz_run  = active.blank_lz;
    blanked = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run     = lz_run && (active.vals[4*i +: 4] == 4'h0);
      blanked[i] = lz_run;
    end
  end

  logic [3:0] nibble;
  logic       dp_sel, en_sel, blank_sel;

  always_comb begin
    nibble    = '0;
    dp_sel    = 1'b0;
    en_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nibble    = active.vals[4*i +: 4];
        dp_sel    = active.dp[i];
        en_sel    = active.en[i];
        blank_sel = blanked[i];
      end
    end
  end

  logic [6:0] glyph;

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (glyph)
  );

  // PWM: on for the first brightness*STEP cycles of each slot; all-ones is
  // forced fully on since STEP*max may fall short of COUNT_TO.
  logic [DUTY_BITS-1:0] bright;
  logic [PW-1:0]        pwm_thr;
  logic                 pwm_on, lit;

  assign bright  = active.brightness[DUTY_BITS-1:0];
  assign pwm_thr = {32'd0, bright} * PW'(STEP);
  assign pwm_on  = (&bright) || (PW'(slot) < pwm_thr);
  assign lit     = en_sel && !blank_sel && pwm_on;

  logic [NUM_DIGITS-1:0] an_d;

  always_comb begin
    an_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (lit && idx == IW'(i)) an_d[i] = 1'b0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_out <= 1'b0;
      an_out    <= '1;
      cat_out   <= SEG_OFF;
      dp_out    <= 1'b1;
    end else begin
      frame_out <= boundary;
      an_out    <= an_d;
      cat_out   <= lit ? ~glyph : SEG_OFF;
      dp_out    <= lit ? ~dp_sel : 1'b1;
    end
  end

endmodule
